mem_stall_ctrl: RTL and testbench

Parametrised memory-access controller between several processor-side request channels and one shared data-memory port. It arbitrates requests, inserts a configurable number of wait states, and drives a per-channel `clk_stall` that holds each requester's clock while its access is in flight. It generalises the single data-memory stall into N channels with programmable latency.

---
 rtl/mem_stall_ctrl_pkg.sv | 14 +
 rtl/mem_stall_arbiter.sv | 63 ++++++
 rtl/mem_stall_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_stall_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the memory stall controller.
// Holds the access FSM state encoding and the wait-state counter limits.
package mem_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam int unsigned WaitStatesMax = 15;
    localparam int unsigned WaitCntW      = 4;

endpackage

// File: rtl/mem_stall_arbiter.sv
// Winner select for the memory stall controller.
// Optional macro MEM_STALL_RR_EN: round-robin search starting at a pointer that
// moves to winner+1 on each grant. Without it, the lowest pending index wins.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (pointer only)
//   pending     - per-channel request pending
//   grant       - high in the cycle the controller accepts the current winner
//   any_pending - at least one channel is pending
//   winner      - index of the selected channel
module mem_stall_arbiter #(
    parameter int unsigned N_CH = 2,
    localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] pending,
    input  logic            grant,
    output logic            any_pending,
    output logic [IdxW-1:0] winner
);

`ifdef MEM_STALL_RR_EN
    logic [IdxW-1:0] ptr_q;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        any_pending = 1'b0;
        winner      = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = (32'(ptr_q) + k) % N_CH;
            if (!any_pending && pending[idx]) begin
                any_pending = 1'b1;
                winner      = IdxW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (grant) begin
            ptr_q <= (winner == IdxW'(N_CH - 1)) ? '0 : winner + 1'b1;
        end
    end
`else
    always_comb begin
        any_pending = 1'b0;
        winner      = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!any_pending && pending[k]) begin
                any_pending = 1'b1;
                winner      = IdxW'(k);
            end
        end
    end

    // Fixed priority keeps no state.
    logic unused_arb_inputs;
    assign unused_arb_inputs = clk ^ reset ^ grant;
`endif

endmodule

// File: rtl/mem_stall_ctrl.sv
// Multi-channel memory access controller with per-channel clock stall.
// Arbitrates N_CH request channels onto one memory port, inserts WAIT_STATES
// extra cycles per access and holds each requester's clock until its DONE cycle.
// Optional macro MEM_STALL_RR_EN selects round-robin arbitration (see arbiter).
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   req_memread/req_memwrite    - per-channel level requests (write wins)
//   req_addr/req_wrdata/req_sign_mask - packed per-channel request fields
//   req_rddata                  - packed per-channel registered read data
//   clk_stall                   - per-channel clock hold
//   mem_*                       - registered shared memory port; mem_rddata in
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        req_memread,
    input  logic [N_CH-1:0]        req_memwrite,
    input  logic [N_CH*ADDR_W-1:0] req_addr,
    input  logic [N_CH*DATA_W-1:0] req_wrdata,
    input  logic [N_CH*4-1:0]      req_sign_mask,
    output logic [N_CH*DATA_W-1:0] req_rddata,
    output logic [N_CH-1:0]        clk_stall,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wrdata,
    output logic                   mem_memread,
    output logic                   mem_memwrite,
    output logic [3:0]             mem_sign_mask,
    input  logic [DATA_W-1:0]      mem_rddata
);

    localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e                 state_q, state_d;
    logic [WaitCntW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [IdxW-1:0]        winner_q, winner_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wrdata_q, wrdata_d;
    logic [3:0]             mask_q, mask_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic [N_CH*DATA_W-1:0] rddata_q, rddata_d;

    logic [N_CH-1:0] pending;
    logic            arb_any;
    logic [IdxW-1:0] arb_winner;
    logic            grant;

    assign pending = req_memread | req_memwrite;

    mem_stall_arbiter #(
        .N_CH (N_CH)
    ) u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .pending     (pending),
        .grant       (grant),
        .any_pending (arb_any),
        .winner      (arb_winner)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        winner_d   = winner_q;
        addr_d     = addr_q;
        wrdata_d   = wrdata_q;
        mask_d     = mask_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        rddata_d   = rddata_q;
        grant      = 1'b0;
        case (state_q)
            StIdle: begin
                if (arb_any) begin
                    grant      = 1'b1;
                    winner_d   = arb_winner;
                    addr_d     = req_addr[arb_winner*ADDR_W +: ADDR_W];
                    wrdata_d   = req_wrdata[arb_winner*DATA_W +: DATA_W];
                    mask_d     = req_sign_mask[arb_winner*4 +: 4];
                    wr_d       = req_memwrite[arb_winner];
                    rd_d       = req_memread[arb_winner] & ~req_memwrite[arb_winner];
                    wait_cnt_d = WaitCntW'(WAIT_STATES);
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                if (wait_cnt_q == '0) begin
                    if (rd_q) begin
                        rddata_d[winner_q*DATA_W +: DATA_W] = mem_rddata;
                    end
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            winner_q   <= '0;
            addr_q     <= '0;
            wrdata_q   <= '0;
            mask_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            rddata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            winner_q   <= winner_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
            mask_q     <= mask_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            rddata_q   <= rddata_d;
        end
    end

    // Stall releases only for the served channel's DONE cycle; it is purely a
    // function of pending, so it also follows the requests during reset.
    always_comb begin
        clk_stall = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            clk_stall[i] = pending[i] & ~((state_q == StDone) && (winner_q == IdxW'(i)));
        end
    end

    assign req_rddata    = rddata_q;
    assign mem_addr      = addr_q;
    assign mem_wrdata    = wrdata_q;
    assign mem_memread   = rd_q;
    assign mem_memwrite  = wr_q;
    assign mem_sign_mask = mask_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
module tb_mem_stall_ctrl;

`ifdef MEM_STALL_RR_EN
    localparam bit Rr = 1'b1;
`else
    localparam bit Rr = 1'b0;
`endif

    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h0000_0020;
    localparam logic [31:0] W0 = 32'h1111_1111;
    localparam logic [31:0] W1 = 32'hCAFE_F00D;
    localparam logic [3:0]  M0 = 4'b0011;
    localparam logic [3:0]  M1 = 4'b1111;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd, wr;
    logic [63:0] req_addr, req_wrdata, req_rddata;
    logic [7:0]  req_mask;
    logic [1:0]  clk_stall;
    logic [31:0] mem_addr, mem_wrdata, mem_rddata;
    logic        mem_memread, mem_memwrite;
    logic [3:0]  mem_sign_mask;

    // Second instance with zero wait states.
    logic [1:0]  rd_b;
    logic [1:0]  wr_b;
    logic [63:0] z_rddata;
    logic [1:0]  z_stall;
    logic [31:0] z_addr, z_wrdata, mem_rddata_b;
    logic        z_rd, z_wr;
    logic [3:0]  z_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .WAIT_STATES(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_memread   (rd),
        .req_memwrite  (wr),
        .req_addr      (req_addr),
        .req_wrdata    (req_wrdata),
        .req_sign_mask (req_mask),
        .req_rddata    (req_rddata),
        .clk_stall     (clk_stall),
        .mem_addr      (mem_addr),
        .mem_wrdata    (mem_wrdata),
        .mem_memread   (mem_memread),
        .mem_memwrite  (mem_memwrite),
        .mem_sign_mask (mem_sign_mask),
        .mem_rddata    (mem_rddata)
    );

    mem_stall_ctrl #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .clk           (clk),
        .reset         (reset),
        .req_memread   (rd_b),
        .req_memwrite  (wr_b),
        .req_addr      (req_addr),
        .req_wrdata    (req_wrdata),
        .req_sign_mask (req_mask),
        .req_rddata    (z_rddata),
        .clk_stall     (z_stall),
        .mem_addr      (z_addr),
        .mem_wrdata    (z_wrdata),
        .mem_memread   (z_rd),
        .mem_memwrite  (z_wr),
        .mem_sign_mask (z_mask),
        .mem_rddata    (mem_rddata_b)
    );

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [1:0]  stall;
        logic        mrd;
        logic        mwr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic full_reset();
        reset = 1'b1;
        rd    = 2'b00;
        wr    = 2'b00;
        rd_b  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mrd", 64'(mem_memread), 64'd0);
        chk("rst_mwr", 64'(mem_memwrite), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wrdata), 64'd0);
        chk("rst_mask", 64'(mem_sign_mask), 64'd0);
        chk("rst_rddata", req_rddata, 64'd0);
        chk("rst_stall", 64'(clk_stall), 64'd0);
        next_cycle();
    endtask

    initial begin
        req_addr     = {A1, A0};
        req_wrdata   = {W1, W0};
        req_mask     = {M1, M0};
        wr_b         = 2'b00;
        mem_rddata   = 32'h55AA_55AA;
        mem_rddata_b = 32'h0F0F_0F0F;

        //            rd     wr     stall  mrd   mwr   addr wdata mask rd0    rd1
        vecs[0] = '{2'b01, 2'b00, 2'b01, 1'b0, 1'b0, '0, '0, '0, '0, '0};
        vecs[1] = '{2'b01, 2'b00, 2'b01, 1'b1, 1'b0, A0, W0, M0, '0, '0};
        vecs[2] = '{2'b01, 2'b00, 2'b01, 1'b1, 1'b0, A0, W0, M0, '0, '0};
        vecs[3] = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, A0, W0, M0, DB, '0};
        vecs[4] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0, W0, M0, DB, '0};
        vecs[5] = '{2'b00, 2'b10, 2'b10, 1'b0, 1'b0, A0, W0, M0, DB, '0};
        vecs[6] = '{2'b00, 2'b10, 2'b10, 1'b0, 1'b1, A1, W1, M1, DB, '0};
        vecs[7] = '{2'b00, 2'b10, 2'b10, 1'b0, 1'b1, A1, W1, M1, DB, '0};
        vecs[8] = '{2'b00, 2'b10, 2'b00, 1'b0, 1'b0, A1, W1, M1, DB, '0};
        vecs[9] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A1, W1, M1, DB, '0};

        full_reset();

        // Reset during the final ACCESS cycle of a ch1 read.
        rd = 2'b10;
        @(negedge clk); chk("d0_stall", 64'(clk_stall), 64'b10);
        chk("d0_mrd", 64'(mem_memread), 64'd0);
        next_cycle();
        @(negedge clk); chk("d1_mrd", 64'(mem_memread), 64'd1);
        chk("d1_addr", 64'(mem_addr), 64'(A1));
        next_cycle();
        reset = 1'b1;
        @(negedge clk); chk("rst_hold_stall", 64'(clk_stall), 64'b10);
        next_cycle();
        reset = 1'b0;
        @(negedge clk); chk("rst_strobe_clr", 64'(mem_memread), 64'd0);
        chk("rst_no_capture", req_rddata, 64'd0);
        chk("rst_stall_idle", 64'(clk_stall), 64'b10);
        next_cycle();
        @(negedge clk); chk("reserve_mrd", 64'(mem_memread), 64'd1);
        chk("reserve_addr", 64'(mem_addr), 64'(A1));
        next_cycle();
        next_cycle();
        @(negedge clk); chk("reserve_done_stall", 64'(clk_stall), 64'b00);
        chk("reserve_rd1", req_rddata[63:32], 64'h55AA_55AA);
        rd = 2'b00;
        next_cycle();

        full_reset();

        // Single read by ch0, then a write by ch1.
        mem_rddata = DB;
        for (int i = 0; i < 10; i++) begin
            rd = vecs[i].rd;
            wr = vecs[i].wr;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 64'(clk_stall), 64'(vecs[i].stall));
            chk($sformatf("v%0d_mrd", i), 64'(mem_memread), 64'(vecs[i].mrd));
            chk($sformatf("v%0d_mwr", i), 64'(mem_memwrite), 64'(vecs[i].mwr));
            chk($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(vecs[i].addr));
            chk($sformatf("v%0d_wdata", i), 64'(mem_wrdata), 64'(vecs[i].wdata));
            chk($sformatf("v%0d_mask", i), 64'(mem_sign_mask), 64'(vecs[i].mask));
            chk($sformatf("v%0d_rd0", i), 64'(req_rddata[31:0]), 64'(vecs[i].rd0));
            chk($sformatf("v%0d_rd1", i), 64'(req_rddata[63:32]), 64'(vecs[i].rd1));
            next_cycle();
        end

        // Both channels read and hold their requests across two accesses.
        mem_rddata = 32'h0BAD_F00D;
        rd = 2'b11;
        @(negedge clk); chk("b0_stall", 64'(clk_stall), 64'b11);
        next_cycle();
        @(negedge clk); chk("b1_first_addr", 64'(mem_addr), 64'(A0));
        next_cycle();
        next_cycle();
        @(negedge clk); chk("b3_stall", 64'(clk_stall), 64'b10);
        chk("b3_rd0", 64'(req_rddata[31:0]), 64'h0BAD_F00D);
        next_cycle();
        @(negedge clk); chk("b4_stall", 64'(clk_stall), 64'b11);
        next_cycle();
        @(negedge clk); chk("b5_second_addr", 64'(mem_addr), Rr ? 64'(A1) : 64'(A0));
        next_cycle();
        next_cycle();
        @(negedge clk); chk("b7_stall", 64'(clk_stall), Rr ? 64'b01 : 64'b10);
        chk("b7_rd1", 64'(req_rddata[63:32]), Rr ? 64'h0BAD_F00D : 64'd0);
        rd = 2'b00;
        next_cycle();
        @(negedge clk); chk("b8_stall", 64'(clk_stall), 64'b00);
        chk("b8_mrd", 64'(mem_memread), 64'd0);
        next_cycle();

        // ch0 withdraws during ACCESS; the access still runs to DONE.
        mem_rddata = 32'h1234_5678;
        rd = 2'b01;
        @(negedge clk); chk("c0_stall", 64'(clk_stall), 64'b01);
        next_cycle();
        @(negedge clk); chk("c1_mrd", 64'(mem_memread), 64'd1);
        next_cycle();
        rd = 2'b00;
        @(negedge clk); chk("withdraw_stall", 64'(clk_stall), 64'b00);
        chk("withdraw_strobe_held", 64'(mem_memread), 64'd1);
        next_cycle();
        rd = 2'b01;
        @(negedge clk); chk("c3_done_stall", 64'(clk_stall), 64'b00);
        chk("c3_done_mrd", 64'(mem_memread), 64'd0);
        chk("c3_rd0", 64'(req_rddata[31:0]), 64'h1234_5678);
        next_cycle();
        @(negedge clk); chk("c4_idle_mrd", 64'(mem_memread), 64'd0);
        chk("c4_stall", 64'(clk_stall), 64'b01);
        next_cycle();
        @(negedge clk); chk("c5_new_access", 64'(mem_memread), 64'd1);
        rd = 2'b00;
        repeat (3) next_cycle();

        // Zero wait states, ch0 read held: one access every 3 cycles.
        rd_b = 2'b01;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("ws0_stall_%0d", k), 64'(z_stall[0]), 64'((k % 3) != 2));
            chk($sformatf("ws0_mrd_%0d", k), 64'(z_rd), 64'((k % 3) == 1));
            if (k == 2) chk("ws0_rd0", 64'(z_rddata[31:0]), 64'h0F0F_0F0F);
            next_cycle();
        end
        rd_b = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
